fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and the instruction memory.
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch stage feeding the IF/ID register,
// with a one-entry hold buffer for stalls and a drain state for squashed requests.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [31:0]   branch_target,
  fetch_unit_if.master  imem,
  output logic [31:0]   instr_out,
  output logic [31:0]   pc_out,
  output logic          valid_out
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   drain_addr_q, drain_addr_d;
  logic [XLEN-1:0]   hold_instr_q, hold_instr_d;
  logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
  logic              hold_vld_q, hold_vld_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;

  // State and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= RESET_PC;
      hold_vld_q   <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_out_q     <= RESET_PC;
      valid_q      <= 1'b0;
      req_q        <= 1'b1;
      addr_q       <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_vld_q   <= hold_vld_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
    end
  end

  // Next-state logic; flush overrides stall and ack in every state
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_vld_d   = hold_vld_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;

    if (flush) begin
      pc_d       = {branch_target[XLEN-1:2], 2'b00};
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      hold_vld_d = 1'b0;
      unique case (state_q)
        FETCH: begin
          if (imem.imem_ack) begin
            state_d = FETCH;
          end else begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end
        HOLD:    state_d = FETCH;
        DRAIN:   state_d = imem.imem_ack ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem.imem_ack) begin
            pc_d = pc_q + XLEN'(4);
            if (stall) begin
              hold_instr_d = imem.imem_data;
              hold_pc_d    = pc_q;
              hold_vld_d   = 1'b1;
              state_d      = HOLD;
            end else begin
              instr_d  = imem.imem_data;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
            end
          end else if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d    = hold_instr_q;
            pc_out_d   = hold_pc_q;
            valid_d    = hold_vld_q;
            hold_vld_d = 1'b0;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          // Response to the squashed request is dropped; IF/ID keeps its bubble
          if (imem.imem_ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end

    req_d  = (state_d != HOLD);
    addr_d = (state_d == DRAIN) ? drain_addr_d : pc_d;
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instr_out      = instr_q;
  assign pc_out         = pc_out_q;
  assign valid_out      = valid_q;
endmodule
